pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_perf_cnt.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared encodings and defaults for the pipeline hazard controller.
package pipe_pkg;

    localparam int XLEN_DEF   = 64;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10
    } fwd_e;

    typedef struct packed {
        logic id;
        logic ex;
        logic mem;
        logic wb;
    } valid_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: cycle, retired-instruction, stall and flush counters.
module pipe_perf_cnt #(
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic            retire,
    input  logic            stall,
    input  logic            flush,
    output logic [CNTW-1:0] cycle_cnt,
    output logic [CNTW-1:0] instret_cnt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    // stall and flush arrive already masked by hold; cycle_cnt runs even when held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            cycle_cnt   <= cycle_cnt + 1'b1;
            instret_cnt <= instret_cnt + CNTW'(retire & ~hold);
            stall_cnt   <= stall_cnt + CNTW'(stall);
            flush_cnt   <= flush_cnt + CNTW'(flush);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC sequencing, load-use stall, branch flush and operand
// forwarding for a five-stage pipeline, with performance counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               NREG     = 32,
    parameter int               CNTW     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    localparam int              RW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hold,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [RW-1:0]   ex_rs1,
    input  logic [RW-1:0]   ex_rs2,
    input  logic [RW-1:0]   ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic [RW-1:0]   mem_rd,
    input  logic            mem_regwrite,
    input  logic [RW-1:0]   wb_rd,
    input  logic            wb_regwrite,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] pc,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            v_id,
    output logic            v_ex,
    output logic            v_mem,
    output logic            v_wb,
    output logic [CNTW-1:0] cycle_cnt,
    output logic [CNTW-1:0] instret_cnt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    valid_t          v, v_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic            active, hz, br, stall;
    logic            mem_fwd_ok, wb_fwd_ok;

    // every control output is masked by reset so the block is quiet while held in reset
    assign active = reset & ~hold;
    assign hz     = v.ex & ex_memread & (ex_rd != '0) & v.id &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign br     = active & br_taken;
    assign stall  = active & ~br_taken & hz;

    assign ifid_en     = ~reset | (~hold & ~stall);
    assign ifid_flush  = br;
    assign idex_flush  = br | stall;
    assign exmem_flush = br;

    // ex_regwrite is not needed here: a load-use hazard only depends on ex_memread
    assign mem_fwd_ok = reset & v.mem & mem_regwrite & (mem_rd != '0);
    assign wb_fwd_ok  = reset & v.wb & wb_regwrite & (wb_rd != '0);

    assign fwd_a = (mem_fwd_ok & (mem_rd == ex_rs1)) ? FWD_EXMEM :
                   (wb_fwd_ok & (wb_rd == ex_rs1))   ? FWD_MEMWB : FWD_RF;
    assign fwd_b = (mem_fwd_ok & (mem_rd == ex_rs2)) ? FWD_EXMEM :
                   (wb_fwd_ok & (wb_rd == ex_rs2))   ? FWD_MEMWB : FWD_RF;

    always_comb begin
        v_nxt  = v;
        pc_nxt = pc;
        if (active) begin
            pc_nxt    = br ? br_target : stall ? pc : pc + XLEN'(INST_BYTES);
            v_nxt.id  = br ? 1'b0 : stall ? v.id : 1'b1;
            v_nxt.ex  = ~br & v.id & ~stall;
            v_nxt.mem = ~br & v.ex;
            v_nxt.wb  = v.mem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
            v  <= '0;
        end else begin
            pc <= pc_nxt;
            v  <= v_nxt;
        end
    end

    assign v_id  = v.id;
    assign v_ex  = v.ex;
    assign v_mem = v.mem;
    assign v_wb  = v.wb;

    pipe_perf_cnt #(.CNTW(CNTW)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .hold        (hold),
        .retire      (v.wb),
        .stall       (stall),
        .flush       (br),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: forwarding vector table plus a per-cycle model scoreboard
// for PC, valid bits and counters; a narrow second instance covers wrap-around.
module tb_pipe_hazard_ctrl;

    localparam int XLEN = 64;
    localparam int RW   = 5;
    localparam int CNTW = 32;

    logic            clk = 1'b0;
    logic            reset, hold;
    logic [RW-1:0]   id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic            id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
    logic            mem_regwrite, wb_regwrite, br_taken;
    logic [XLEN-1:0] br_target;

    logic [XLEN-1:0] pc;
    logic            ifid_en, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]      fwd_a, fwd_b;
    logic            v_id, v_ex, v_mem, v_wb;
    logic [CNTW-1:0] cycle_cnt, instret_cnt, stall_cnt, flush_cnt;

    logic [31:0]     pc_w;
    logic            w_ifid_en, w_ifid_flush, w_idex_flush, w_exmem_flush;
    logic [1:0]      w_fwd_a, w_fwd_b;
    logic            w_v_id, w_v_ex, w_v_mem, w_v_wb;
    logic [3:0]      cyc_w, ret_w, stl_w, fl_w;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk(clk), .reset(reset), .hold(hold),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .br_taken(br_taken), .br_target(br_target),
        .pc(pc), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .v_id(v_id), .v_ex(v_ex), .v_mem(v_mem), .v_wb(v_wb),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.XLEN(32), .CNTW(4), .RESET_PC(32'hFFFF_FFFC)) u_w (
        .clk(clk), .reset(reset), .hold(hold),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .br_taken(1'b0), .br_target(32'h0),
        .pc(pc_w), .ifid_en(w_ifid_en), .ifid_flush(w_ifid_flush), .idex_flush(w_idex_flush),
        .exmem_flush(w_exmem_flush), .fwd_a(w_fwd_a), .fwd_b(w_fwd_b),
        .v_id(w_v_id), .v_ex(w_v_ex), .v_mem(w_v_mem), .v_wb(w_v_wb),
        .cycle_cnt(cyc_w), .instret_cnt(ret_w), .stall_cnt(stl_w), .flush_cnt(fl_w)
    );

    typedef struct {
        logic [RW-1:0] mem_rd, wb_rd, ex_rs1, ex_rs2;
        logic          mem_rw, wb_rw;
        logic [1:0]    ea, eb;
    } fvec_t;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [3:0]      v;
        logic [CNTW-1:0] cyc, ret, stl, fl;
    } exp_t;

    fvec_t ftab[7];
    exp_t  sbq[$];
    int    n_vec = 0;
    int    n_err = 0;

    logic [XLEN-1:0] m_pc;
    logic [3:0]      m_v;
    logic [CNTW-1:0] m_cyc, m_ret, m_stl, m_fl;
    logic [XLEN-1:0] pc_save;
    logic [CNTW-1:0] cyc_save, ret_save, stl_save;
    logic [3:0]      v_save;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mreset();
        m_pc = '0; m_v = '0; m_cyc = '0; m_ret = '0; m_stl = '0; m_fl = '0;
        sbq.delete();
    endtask

    task automatic clr();
        hold = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
        br_taken = 0; br_target = '0;
    endtask

    // m_v is {id, ex, mem, wb}
    task automatic step();
        logic hz, br, st;
        exp_t e;
        #1;
        hz = m_v[2] && ex_memread && (ex_rd != 0) && m_v[3] &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        br = !hold && br_taken;
        st = !hold && !br_taken && hz;
        chk("ifid_en", ifid_en, !hold && !st);
        chk("ifid_flush", ifid_flush, br);
        chk("idex_flush", idex_flush, br || st);
        chk("exmem_flush", exmem_flush, br);
        m_cyc++;
        if (!hold) begin
            m_pc  = br ? br_target : st ? m_pc : m_pc + 4;
            m_ret = m_ret + m_v[0];
            m_stl = m_stl + st;
            m_fl  = m_fl + br;
            m_v   = br ? {3'b000, m_v[1]} : {st ? m_v[3] : 1'b1, m_v[3] && !st, m_v[2], m_v[1]};
        end
        e = '{m_pc, m_v, m_cyc, m_ret, m_stl, m_fl};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("pc", pc, e.pc);
        chk("valid", {v_id, v_ex, v_mem, v_wb}, e.v);
        chk("cycle_cnt", cycle_cnt, e.cyc);
        chk("instret_cnt", instret_cnt, e.ret);
        chk("stall_cnt", stall_cnt, e.stl);
        chk("flush_cnt", flush_cnt, e.fl);
    endtask

    initial begin
        ftab[0] = '{7, 7, 7, 7, 1'b1, 1'b1, 2'b10, 2'b10};
        ftab[1] = '{0, 7, 7, 7, 1'b1, 1'b1, 2'b01, 2'b01};
        ftab[2] = '{0, 0, 0, 0, 1'b1, 1'b1, 2'b00, 2'b00};
        ftab[3] = '{7, 7, 7, 7, 1'b0, 1'b1, 2'b01, 2'b01};
        ftab[4] = '{7, 3, 7, 3, 1'b1, 1'b1, 2'b10, 2'b01};
        ftab[5] = '{5, 6, 5, 6, 1'b1, 1'b0, 2'b10, 2'b00};
        ftab[6] = '{4, 4, 9, 4, 1'b1, 1'b1, 2'b00, 2'b10};

        clr();
        reset = 0;
        br_taken = 1; br_target = 64'h55; mem_rd = 3; mem_regwrite = 1; ex_rs1 = 3;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 0);
        chk("rst_valid", {v_id, v_ex, v_mem, v_wb}, 0);
        chk("rst_counters", {cycle_cnt, instret_cnt, stall_cnt, flush_cnt}, 0);
        chk("rst_ifid_en", ifid_en, 1);
        chk("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 0);
        chk("rst_fwd", {fwd_a, fwd_b}, 0);
        chk("rst_pc_w", pc_w, 32'hFFFF_FFFC);
        clr();
        @(negedge clk);
        reset = 1;
        mreset();

        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 1) chk("pc32_wrap", pc_w, 0);
            if (i == 3) chk("v_wb_c3", v_wb, 0);
            if (i == 4) begin
                chk("v_wb_c4", v_wb, 1);
                chk("pc_c4", pc, 16);
            end
            if (i == 5) chk("instret_c5", instret_cnt, 1);
            if (i == 15) chk("cnt4_15", cyc_w, 15);
            if (i == 16) chk("cnt4_wrap", cyc_w, 0);
        end

        for (int i = 0; i < 7; i++) begin
            mem_rd = ftab[i].mem_rd; wb_rd = ftab[i].wb_rd;
            ex_rs1 = ftab[i].ex_rs1; ex_rs2 = ftab[i].ex_rs2;
            mem_regwrite = ftab[i].mem_rw; wb_regwrite = ftab[i].wb_rw;
            #1;
            chk($sformatf("fwd_a[%0d]", i), fwd_a, ftab[i].ea);
            chk($sformatf("fwd_b[%0d]", i), fwd_b, ftab[i].eb);
            step();
        end
        clr();

        // load x5 in EX, add x6,x5,x1 in ID
        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1; id_rs2 = 1; id_use_rs2 = 1;
        #1;
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_idex_flush", idex_flush, 1);
        pc_save = pc;
        step();
        chk("lu_pc_held", pc, pc_save);
        chk("lu_stall_cnt", stall_cnt, 1);
        mem_rd = 5; mem_regwrite = 1;
        #1;
        chk("lu_one_cycle", ifid_en, 1);
        step();
        ex_memread = 0; ex_rd = 6; ex_rs1 = 5; ex_rs2 = 1;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 5; wb_regwrite = 1;
        #1;
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_fwd_b", fwd_b, 2'b00);
        step();
        clr();

        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        br_taken = 1; br_target = 64'h100;
        stl_save = stall_cnt;
        #1;
        chk("br_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        step();
        chk("br_pc", pc, 64'h100);
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, stl_save);
        chk("br_valid", {v_id, v_ex, v_mem}, 0);
        clr();
        repeat (4) step();

        hold = 1; br_taken = 1; br_target = 64'h200;
        pc_save = pc; cyc_save = cycle_cnt; ret_save = instret_cnt;
        v_save = {v_id, v_ex, v_mem, v_wb};
        #1;
        chk("hold_ifid_en", ifid_en, 0);
        chk("hold_flushes", {ifid_flush, idex_flush, exmem_flush}, 0);
        repeat (3) step();
        chk("hold_pc", pc, pc_save);
        chk("hold_cycle", cycle_cnt, cyc_save + 3);
        chk("hold_instret", instret_cnt, ret_save);
        chk("hold_valid", {v_id, v_ex, v_mem, v_wb}, v_save);
        hold = 0;
        step();
        chk("hold_br_pc", pc, 64'h200);
        br_taken = 0;
        step();
        repeat (3) step();

        ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        #1;
        chk("rs_pre_stall", ifid_en, 0);
        reset = 0;
        #1;
        chk("rs_pc", pc, 0);
        chk("rs_valid", {v_id, v_ex, v_mem, v_wb}, 0);
        chk("rs_counters", {cycle_cnt, instret_cnt, stall_cnt, flush_cnt}, 0);
        chk("rs_ifid_en", ifid_en, 1);
        chk("rs_idex_flush", idex_flush, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        mreset();
        step();
        chk("rs_first_fetch", pc, 4);
        step();
        clr();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
